// File: rtl/maq_mh_if.sv
// Minutes/hours stage bus: count inputs and pushbuttons in, BCD digits, mode and day carry out.
// master drives the inputs (seconds stage / buttons); slave is the counter itself.
interface maq_mh_if;
  logic       maqmh_enable;
  logic       maqmh_incrementaminuto;
  logic       maqmh_set_btn;
  logic       maqmh_inc_btn;
  logic [3:0] maqmh_min_lsd;
  logic [2:0] maqmh_min_msd;
  logic [3:0] maqmh_hour_lsd;
  logic [1:0] maqmh_hour_msd;
  logic [1:0] maqmh_mode;
  logic       maqmh_incrementadia;

  modport master (
    output maqmh_enable, maqmh_incrementaminuto, maqmh_set_btn, maqmh_inc_btn,
    input  maqmh_min_lsd, maqmh_min_msd, maqmh_hour_lsd, maqmh_hour_msd,
           maqmh_mode, maqmh_incrementadia
  );

  modport slave (
    input  maqmh_enable, maqmh_incrementaminuto, maqmh_set_btn, maqmh_inc_btn,
    output maqmh_min_lsd, maqmh_min_msd, maqmh_hour_lsd, maqmh_hour_msd,
           maqmh_mode, maqmh_incrementadia
  );
endinterface

// File: rtl/maq_mh.sv
// BCD minutes/hours counter with RUN/SET_HOUR/SET_MIN adjust FSM and one-cycle day-carry pulse.
// All outputs registered; an input rising edge shows up one cycle later; no backpressure.
module maq_mh #(
  parameter int MAX_HOUR = 23
) (
  input logic      maqmh_clock,
  input logic      maqmh_reset,
  maq_mh_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_e;

  localparam logic [1:0] MH_MSD = 2'(MAX_HOUR / 10);
  localparam logic [3:0] MH_LSD = 4'(MAX_HOUR % 10);

  mode_e      mode_q, mode_d;
  logic [3:0] min_lsd_q, min_lsd_d;
  logic [2:0] min_msd_q, min_msd_d;
  logic [3:0] hour_lsd_q, hour_lsd_d;
  logic [1:0] hour_msd_q, hour_msd_d;
  logic       dia_q, dia_d;
  logic       min_prev_q, min_prev_d;
  logic       set_prev_q, set_prev_d;
  logic       inc_prev_q, inc_prev_d;

  logic       min_edge, set_edge, inc_edge;
  logic       min_wrap, hour_wrap;
  logic [3:0] min_lsd_nx, hour_lsd_nx;
  logic [2:0] min_msd_nx;
  logic [1:0] hour_msd_nx;

  assign min_edge = bus.maqmh_incrementaminuto & ~min_prev_q;
  assign set_edge = bus.maqmh_set_btn & ~set_prev_q;
  assign inc_edge = bus.maqmh_inc_btn & ~inc_prev_q;

  // Incremented values of each field, shared by counting and manual adjust.
  always_comb begin
    min_wrap  = (min_msd_q == 3'd5) && (min_lsd_q == 4'd9);
    hour_wrap = (hour_msd_q == MH_MSD) && (hour_lsd_q == MH_LSD);

    if (min_wrap) begin
      min_msd_nx = 3'd0;
      min_lsd_nx = 4'd0;
    end else if (min_lsd_q == 4'd9) begin
      min_msd_nx = min_msd_q + 3'd1;
      min_lsd_nx = 4'd0;
    end else begin
      min_msd_nx = min_msd_q;
      min_lsd_nx = min_lsd_q + 4'd1;
    end

    if (hour_wrap) begin
      hour_msd_nx = 2'd0;
      hour_lsd_nx = 4'd0;
    end else if (hour_lsd_q == 4'd9) begin
      hour_msd_nx = hour_msd_q + 2'd1;
      hour_lsd_nx = 4'd0;
    end else begin
      hour_msd_nx = hour_msd_q;
      hour_lsd_nx = hour_lsd_q + 4'd1;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    min_lsd_d  = min_lsd_q;
    min_msd_d  = min_msd_q;
    hour_lsd_d = hour_lsd_q;
    hour_msd_d = hour_msd_q;
    dia_d      = 1'b0;
    min_prev_d = bus.maqmh_incrementaminuto;
    set_prev_d = bus.maqmh_set_btn;
    inc_prev_d = bus.maqmh_inc_btn;

    case (mode_q)
      RUN: begin
        if (min_edge && bus.maqmh_enable) begin
          min_lsd_d = min_lsd_nx;
          min_msd_d = min_msd_nx;
          if (min_wrap) begin
            hour_lsd_d = hour_lsd_nx;
            hour_msd_d = hour_msd_nx;
            dia_d      = hour_wrap;
          end
        end
        if (set_edge) mode_d = SET_HOUR;
      end
      // A set edge beats a simultaneous inc edge in both adjust modes.
      SET_HOUR: begin
        if (set_edge) begin
          mode_d = SET_MIN;
        end else if (inc_edge) begin
          hour_lsd_d = hour_lsd_nx;
          hour_msd_d = hour_msd_nx;
        end
      end
      SET_MIN: begin
        if (set_edge) begin
          mode_d = RUN;
        end else if (inc_edge) begin
          min_lsd_d = min_lsd_nx;
          min_msd_d = min_msd_nx;
        end
      end
      default: mode_d = RUN;
    endcase
  end

  // Prev registers reset high so inputs held through reset give no edge.
  always_ff @(posedge maqmh_clock or negedge maqmh_reset) begin
    if (!maqmh_reset) begin
      mode_q     <= RUN;
      min_lsd_q  <= 4'd0;
      min_msd_q  <= 3'd0;
      hour_lsd_q <= 4'd0;
      hour_msd_q <= 2'd0;
      dia_q      <= 1'b0;
      min_prev_q <= 1'b1;
      set_prev_q <= 1'b1;
      inc_prev_q <= 1'b1;
    end else begin
      mode_q     <= mode_d;
      min_lsd_q  <= min_lsd_d;
      min_msd_q  <= min_msd_d;
      hour_lsd_q <= hour_lsd_d;
      hour_msd_q <= hour_msd_d;
      dia_q      <= dia_d;
      min_prev_q <= min_prev_d;
      set_prev_q <= set_prev_d;
      inc_prev_q <= inc_prev_d;
    end
  end

  assign bus.maqmh_min_lsd       = min_lsd_q;
  assign bus.maqmh_min_msd       = min_msd_q;
  assign bus.maqmh_hour_lsd      = hour_lsd_q;
  assign bus.maqmh_hour_msd      = hour_msd_q;
  assign bus.maqmh_mode          = mode_q;
  assign bus.maqmh_incrementadia = dia_q;

endmodule

// File: tb/tb_maq_mh.sv
// Directed bench for maq_mh: two instances (MAX_HOUR 23 and 11) share one set of inputs.
module tb_maq_mh;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic min_in = 1'b1;
  logic set_btn = 1'b0;
  logic inc_btn = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   dia_cnt23 = 0;
  int   dia_cnt11 = 0;

  always #5 clk = ~clk;

  maq_mh_if if23();
  maq_mh_if if11();

  assign if23.maqmh_enable           = enable;
  assign if23.maqmh_incrementaminuto = min_in;
  assign if23.maqmh_set_btn          = set_btn;
  assign if23.maqmh_inc_btn          = inc_btn;
  assign if11.maqmh_enable           = enable;
  assign if11.maqmh_incrementaminuto = min_in;
  assign if11.maqmh_set_btn          = set_btn;
  assign if11.maqmh_inc_btn          = inc_btn;

  maq_mh #(.MAX_HOUR(23)) u_dut23 (.maqmh_clock(clk), .maqmh_reset(rst_n), .bus(if23));
  maq_mh #(.MAX_HOUR(11)) u_dut11 (.maqmh_clock(clk), .maqmh_reset(rst_n), .bus(if11));

  always @(negedge clk) begin
    if (if23.maqmh_incrementadia) dia_cnt23++;
    if (if11.maqmh_incrementadia) dia_cnt11++;
  end

  function automatic int t23();
    return int'(if23.maqmh_hour_msd) * 1000 + int'(if23.maqmh_hour_lsd) * 100 +
           int'(if23.maqmh_min_msd) * 10 + int'(if23.maqmh_min_lsd);
  endfunction

  function automatic int t11();
    return int'(if11.maqmh_hour_msd) * 1000 + int'(if11.maqmh_hour_lsd) * 100 +
           int'(if11.maqmh_min_msd) * 10 + int'(if11.maqmh_min_lsd);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_set();
    set_btn = 1'b1; tick();
    set_btn = 1'b0; tick();
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      inc_btn = 1'b1; tick();
      inc_btn = 1'b0; tick();
    end
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin
      min_in = 1'b1; tick();
      min_in = 1'b0; tick();
    end
  endtask

  initial begin
    // Power-on reset, minute carry already high
    #3;
    chk("rst_time", t23(), 0);
    chk("rst_mode", int'(if23.maqmh_mode), 0);
    chk("rst_dia", int'(if23.maqmh_incrementadia), 0);
    chk("rst_time11", t11(), 0);
    @(negedge clk) rst_n = 1'b1;
    tick(5);
    chk("held_thru_rst", t23(), 0);
    min_in = 1'b0; tick();

    // Set sequence from 00:00
    press_set();
    chk("mode_set_hour", int'(if23.maqmh_mode), 1);
    press_inc(25);
    chk("set_hour_wrap", t23(), 100);
    press_set();
    chk("mode_set_min", int'(if23.maqmh_mode), 2);
    press_inc(61);
    chk("set_min_wrap", t23(), 101);
    press_set();
    chk("mode_run", int'(if23.maqmh_mode), 0);
    chk("set_no_dia", dia_cnt23, 0);

    // Level-held minute carry
    min_in = 1'b1; tick();
    chk("lvl1_first", t23(), 102);
    tick(49);
    chk("lvl1_hold", t23(), 102);
    min_in = 1'b0; tick();
    min_in = 1'b1; tick();
    chk("lvl2_first", t23(), 103);
    tick(49);
    chk("lvl2_hold", t23(), 103);
    min_in = 1'b0; tick();

    // Suspension in SET_HOUR, then simultaneous set+inc
    press_set();
    pulse_min(3);
    chk("suspend_time", t23(), 103);
    chk("suspend_mode", int'(if23.maqmh_mode), 1);
    set_btn = 1'b1; inc_btn = 1'b1; tick();
    set_btn = 1'b0; inc_btn = 1'b0; tick();
    chk("setinc_mode", int'(if23.maqmh_mode), 2);
    chk("setinc_time", t23(), 103);
    press_set();

    // Enable gating in RUN
    enable = 1'b0;
    pulse_min(3);
    chk("en_gate_time", t23(), 103);
    enable = 1'b1; tick();
    chk("en_no_defer", t23(), 103);

    // Set + minute edge together at 09:59
    press_set(); press_inc(8);
    press_set(); press_inc(56);
    press_set();
    chk("preset_0959", t23(), 959);
    set_btn = 1'b1; min_in = 1'b1; tick();
    chk("setmin_time", t23(), 1000);
    chk("setmin_mode", int'(if23.maqmh_mode), 1);
    set_btn = 1'b0; min_in = 1'b0; tick();

    // Asynchronous reset at 13:47 in SET_MIN
    press_inc(3); press_set(); press_inc(47);
    chk("preset_1347", t23(), 1347);
    chk("preset_mode", int'(if23.maqmh_mode), 2);
    min_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_time", t23(), 0);
    chk("arst_mode", int'(if23.maqmh_mode), 0);
    chk("arst_dia", int'(if23.maqmh_incrementadia), 0);
    @(negedge clk) rst_n = 1'b1;
    tick(3);
    chk("arst_no_edge", t23(), 0);
    min_in = 1'b0; tick();

    // Rollover: MAX_HOUR=11 wraps at 11:59, MAX_HOUR=23 goes to 12:00
    press_set(); press_inc(11);
    press_set(); press_inc(59);
    press_set();
    chk("preset_1159", t11(), 1159);
    min_in = 1'b1; tick();
    chk("roll11_time", t11(), 0);
    chk("roll11_dia", int'(if11.maqmh_incrementadia), 1);
    chk("noroll23_time", t23(), 1200);
    chk("noroll23_dia", int'(if23.maqmh_incrementadia), 0);
    min_in = 1'b0; tick();
    chk("roll11_dia_off", int'(if11.maqmh_incrementadia), 0);

    press_set(); press_inc(11);
    press_set(); press_inc(59);
    press_set();
    chk("preset_2359", t23(), 2359);
    min_in = 1'b1; tick();
    chk("roll23_time", t23(), 0);
    chk("roll23_dia", int'(if23.maqmh_incrementadia), 1);
    chk("roll11b_time", t11(), 0);
    min_in = 1'b0; tick();
    chk("roll23_dia_off", int'(if23.maqmh_incrementadia), 0);
    tick(3);
    chk("dia_cnt23", dia_cnt23, 1);
    chk("dia_cnt11", dia_cnt11, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
